// File: rtl/brute_gen.sv
// brute_gen: enumerates every string over [CHAR_MIN..CHAR_MAX], shortest first,
// and offers each one as a right-aligned 128-bit word over valid/ready.
module brute_gen #(
  parameter int         MAX_LEN  = 4,
  parameter logic [7:0] CHAR_MIN = 8'h61,
  parameter logic [7:0] CHAR_MAX = 8'h7A
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic [31:0]  max_attempts,
  output logic [127:0] candidate,
  output logic         cand_valid,
  input  logic         cand_ready,
  output logic [31:0]  attempt_count,
  output logic         done,
  output logic         exhausted
);

  localparam int CW = 8 * MAX_LEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      len_q, len_d;
  logic [CW-1:0]   chars_q, chars_d;
  logic [31:0]     limit_q, limit_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            exh_q, exh_d;

  logic            hs;
  logic            limit_hit;
  logic            carry;
  logic            ks_end;
  logic [CW-1:0]   adv;
  logic [4:0]      adv_len;
  logic [31:0]     cnt_inc;

  // Odometer step; bytes at or above len stay zero so chars_q is the word.
  always_comb begin
    adv     = chars_q;
    adv_len = len_q;
    carry   = 1'b1;
    ks_end  = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (carry && (5'(i) < len_q)) begin
        if (chars_q[8*i +: 8] == CHAR_MAX) begin
          adv[8*i +: 8] = CHAR_MIN;
        end else begin
          adv[8*i +: 8] = chars_q[8*i +: 8] + 8'd1;
          carry         = 1'b0;
        end
      end
    end
    if (carry) begin
      if (len_q < 5'(MAX_LEN)) begin
        adv_len = len_q + 5'd1;
        adv     = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
          if (5'(i) < adv_len) adv[8*i +: 8] = CHAR_MIN;
        end
      end else begin
        ks_end = 1'b1;
      end
    end
  end

  always_comb begin
    hs        = (state_q == RUN) && cand_ready;
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
    limit_hit = (limit_q != 32'd0) &&
                (({1'b0, cnt_q} + 33'd1) == {1'b0, limit_q});
    state_d   = state_q;
    len_d     = len_q;
    chars_d   = chars_q;
    limit_d   = limit_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    exh_d     = exh_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          len_d   = 5'd1;
          chars_d = CW'(CHAR_MIN);
          cnt_d   = '0;
          limit_d = max_attempts;
          done_d  = 1'b0;
          exh_d   = 1'b0;
        end
      end
      RUN: begin
        if (hs) cnt_d = cnt_inc;
        if (stop) begin
          state_d = IDLE;
        end else if (hs) begin
          if (limit_hit) begin
            state_d = DONE;
            done_d  = 1'b1;
            exh_d   = 1'b0;
          end else if (ks_end) begin
            state_d = DONE;
            done_d  = 1'b1;
            exh_d   = 1'b1;
          end else begin
            chars_d = adv;
            len_d   = adv_len;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      chars_q <= '0;
      limit_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      exh_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      chars_q <= chars_d;
      limit_q <= limit_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      exh_q   <= exh_d;
    end
  end

  assign candidate     = 128'(chars_q);
  assign cand_valid    = valid_q;
  assign attempt_count = cnt_q;
  assign done          = done_q;
  assign exhausted     = exh_q;

endmodule

// File: tb/tb_brute_gen.sv
// tb_brute_gen: randomized scoreboard bench for brute_gen
// against an arithmetic model of the enumeration order.
module tb_brute_gen;

  localparam int         ML = 2;
  localparam logic [7:0] CMIN = 8'h61;
  localparam logic [7:0] CMAX = 8'h63;
  localparam int         N = int'(CMAX) - int'(CMIN) + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic [31:0]  max_attempts = '0;
  logic [127:0] candidate;
  logic         cand_valid;
  logic         cand_ready = 1'b0;
  logic [31:0]  attempt_count;
  logic         done;
  logic         exhausted;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int exp_idx = 0;
  logic [127:0] exp_q[$];
  logic         stall_q = 1'b0;
  logic [127:0] prev_cand = '0;
  logic [31:0]  prev_cnt = '0;

  brute_gen #(
    .MAX_LEN(ML), .CHAR_MIN(CMIN), .CHAR_MAX(CMAX)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .max_attempts(max_attempts), .candidate(candidate),
    .cand_valid(cand_valid), .cand_ready(cand_ready),
    .attempt_count(attempt_count), .done(done),
    .exhausted(exhausted)
  );

  always #5 clk = ~clk;

  function automatic int keyspace();
    int s = 0;
    int p = 1;
    for (int l = 1; l <= ML; l++) begin
      p = p * N;
      s = s + p;
    end
    return s;
  endfunction

  // k-th string (0-based): find its length, then write k in base N
  function automatic logic [127:0] model(int k);
    logic [127:0] r = '0;
    int l = 1;
    int p = N;
    while (k >= p) begin
      k = k - p;
      l++;
      p = p * N;
    end
    for (int i = 0; i < l; i++) begin
      r[8*i +: 8] = CMIN + 8'(k % N);
      k = k / N;
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rdy_mode == 2) cand_ready = 1'($urandom_range(0, 1));
    else cand_ready = (rdy_mode == 1);
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (stall_q && cand_valid) begin
        chk("hold_cand", candidate, prev_cand);
        chk("hold_cnt", 128'(attempt_count), 128'(prev_cnt));
      end
      if (cand_valid && cand_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_hs: got %h expected none", candidate);
        end else begin
          chk("cand", candidate, exp_q.pop_front());
          chk("cnt", 128'(attempt_count), 128'(exp_idx));
          if (exp_idx == 3) chk("aa_word", candidate, 128'h6161);
          exp_idx++;
        end
      end
      stall_q   = cand_valid && !cand_ready;
      prev_cand = candidate;
      prev_cnt  = attempt_count;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic do_start(int lim);
    int n;
    n = (lim == 0 || lim > keyspace()) ? keyspace() : lim;
    @(posedge clk);
    #1;
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(model(k));
    exp_idx = 0;
    max_attempts = 32'(lim);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(string nm);
    int n = 0;
    while (!done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: got done=0 expected done=1", nm);
    end
    @(posedge clk);
    #1;
    chk({nm, "_q_empty"}, 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    #2;
    chk("rst_cand", candidate, '0);
    chk("rst_valid", 128'(cand_valid), 128'd0);
    chk("rst_cnt", 128'(attempt_count), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_exh", 128'(exhausted), 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    rdy_mode = 1;
    do_start(0);
    chk("first_a", candidate, 128'h61);
    wait_done("full");
    chk("full_exh", 128'(exhausted), 128'd1);
    chk("full_cnt", 128'(attempt_count), 128'(keyspace()));
    chk("full_last", candidate, model(keyspace() - 1));
    chk("full_valid", 128'(cand_valid), 128'd0);

    do_start(5);
    wait_done("lim5");
    chk("lim5_done", 128'(done), 128'd1);
    chk("lim5_exh", 128'(exhausted), 128'd0);
    chk("lim5_cnt", 128'(attempt_count), 128'd5);
    chk("lim5_last", candidate, model(4));

    rdy_mode = 2;
    do_start(0);
    chk("rs_done_drop", 128'(done), 128'd0);
    wait_done("bp");
    chk("bp_exh", 128'(exhausted), 128'd1);
    chk("bp_cnt", 128'(attempt_count), 128'(keyspace()));

    rdy_mode = 1;
    repeat (2) @(posedge clk);
    do_start(0);
    repeat (3) @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    chk("stop_cnt", 128'(attempt_count), 128'd4);
    chk("stop_valid", 128'(cand_valid), 128'd0);
    chk("stop_done", 128'(done), 128'd0);
    chk("stop_left", 128'(exp_q.size()), 128'(keyspace() - 4));
    @(posedge clk);
    #1;
    chk("idle_valid", 128'(cand_valid), 128'd0);

    rdy_mode = 0;
    repeat (2) @(posedge clk);
    do_start(0);
    chk("re_cand", candidate, 128'h61);
    chk("re_cnt", 128'(attempt_count), 128'd0);
    chk("re_valid", 128'(cand_valid), 128'd1);
    rdy_mode = 1;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_cand", candidate, '0);
    chk("arst_valid", 128'(cand_valid), 128'd0);
    chk("arst_cnt", 128'(attempt_count), 128'd0);
    chk("arst_done", 128'(done), 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_valid", 128'(cand_valid), 128'd0);

    do_start(keyspace());
    wait_done("lim_ks");
    chk("limks_exh", 128'(exhausted), 128'd0);
    chk("limks_cnt", 128'(attempt_count), 128'(keyspace()));

    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    chk("done_stop", 128'(done), 128'd1);

    rdy_mode = 0;
    repeat (2) @(posedge clk);
    do_start(0);
    chk("rd_done", 128'(done), 128'd0);
    chk("rd_cand", candidate, 128'h61);
    chk("rd_cnt", 128'(attempt_count), 128'd0);
    rdy_mode = 2;
    wait_done("rd");
    chk("rd_exh", 128'(exhausted), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
